// File: rtl/buffer_drain_ctrl.sv
// Fill -> hold -> drain sequencer that drives the buffer fill counter's
// emptyBuffer/pause controls, counts completed drains and flags bad levels.
module buffer_drain_ctrl #(
  parameter logic [3:0]  FULL_LEVEL  = 4'd10,
  parameter logic [3:0]  EMPTY_LEVEL = 4'd1,
  parameter logic [18:0] HOLD_CYCLES = 19'd390625
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] percent,
  input  logic       enable,
  input  logic       abort,
  output logic       emptyBuffer,
  output logic       pause,
  output logic [1:0] state,
  output logic       full,
  output logic       transferDone,
  output logic [7:0] transferCount,
  output logic       error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FILL  = 2'b01,
    S_HOLD  = 2'b10,
    S_DRAIN = 2'b11
  } state_e;

  localparam logic [3:0]  MAX_LEVEL = 4'd10;
  localparam logic [18:0] HOLD_LAST = HOLD_CYCLES - 19'd1;

  state_e      state_q, state_d;
  logic [18:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]  count_q, count_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic out_of_range;
  assign out_of_range = (percent > MAX_LEVEL);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    count_d    = count_q;
    done_d     = 1'b0;
    error_d    = error_q;

    if (abort) begin
      state_d    = S_IDLE;
      hold_cnt_d = 19'd0;
    end else if (((state_q == S_FILL) || (state_q == S_DRAIN)) && out_of_range) begin
      // A level above 10 means the fill counter wrapped; latch it until reset.
      error_d = 1'b1;
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (enable && !error_q) state_d = S_FILL;
        end
        S_FILL: begin
          if (percent >= FULL_LEVEL) begin
            state_d    = S_HOLD;
            hold_cnt_d = 19'd0;
          end else if (!enable) begin
            state_d = S_IDLE;
          end
        end
        S_HOLD: begin
          // Enable is ignored here so a started transfer always drains.
          if (hold_cnt_q == HOLD_LAST) begin
            state_d    = S_DRAIN;
            hold_cnt_d = 19'd0;
          end else begin
            hold_cnt_d = hold_cnt_q + 19'd1;
          end
        end
        S_DRAIN: begin
          if (percent <= EMPTY_LEVEL) begin
            done_d  = 1'b1;
            count_d = sat_inc8(count_q);
            state_d = enable ? S_FILL : S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= 19'd0;
      count_q    <= 8'd0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      count_q    <= count_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Moore outputs decoded from the registered state.
  assign state         = state_q;
  assign pause         = (state_q == S_IDLE) || (state_q == S_HOLD);
  assign emptyBuffer   = (state_q == S_DRAIN);
  assign full          = (state_q == S_HOLD);
  assign transferDone  = done_q;
  assign transferCount = count_q;
  assign error         = error_q;

endmodule

// File: tb/tb_buffer_drain_ctrl.sv
// Bench for buffer_drain_ctrl: directed test-plan sequences plus randomized
// traffic, all checked cycle by cycle against a behavioural reference model.
module tb_buffer_drain_ctrl;

  localparam int HOLD = 4;

  logic       clock = 1'b0;
  logic       reset, enable, abort;
  logic [3:0] percent;
  logic       emptyBuffer, pause, full, transferDone, error;
  logic [1:0] state;
  logic [7:0] transferCount;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode 0=idle 1=fill 2=hold 3=drain
  int m_mode = 0;
  int m_hold_left = 0;
  int m_count = 0;
  bit m_done = 0;
  bit m_err = 0;

  buffer_drain_ctrl #(
    .FULL_LEVEL (4'd10),
    .EMPTY_LEVEL(4'd1),
    .HOLD_CYCLES(19'd4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .percent      (percent),
    .enable       (enable),
    .abort        (abort),
    .emptyBuffer  (emptyBuffer),
    .pause        (pause),
    .state        (state),
    .full         (full),
    .transferDone (transferDone),
    .transferCount(transferCount),
    .error        (error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit a, input bit e, input int pct);
    m_done = 0;
    if (r) begin
      m_mode = 0; m_count = 0; m_err = 0; m_hold_left = 0;
    end else if (a) begin
      m_mode = 0;
    end else if ((m_mode == 1 || m_mode == 3) && pct > 10) begin
      m_err = 1; m_mode = 0;
    end else begin
      case (m_mode)
        0: if (e && !m_err) m_mode = 1;
        1: begin
          if (pct >= 10) begin m_mode = 2; m_hold_left = HOLD; end
          else if (!e) m_mode = 0;
        end
        2: begin
          m_hold_left--;
          if (m_hold_left == 0) m_mode = 3;
        end
        default: begin
          if (pct <= 1) begin
            m_done = 1;
            if (m_count < 255) m_count++;
            m_mode = e ? 1 : 0;
          end
        end
      endcase
    end
  endtask

  task automatic check_outputs();
    chk("state", state, m_mode);
    chk("pause", pause, (m_mode == 0 || m_mode == 2));
    chk("emptyBuffer", emptyBuffer, (m_mode == 3));
    chk("full", full, (m_mode == 2));
    chk("transferDone", transferDone, m_done);
    chk("transferCount", transferCount, m_count);
    chk("error", error, m_err);
  endtask

  task automatic step(input bit r, input bit a, input bit e, input int pct);
    reset = r; abort = a; enable = e; percent = 4'(pct);
    @(posedge clock);
    model_step(r, a, e, pct);
    #1;
    check_outputs();
  endtask

  task automatic run_to_drain();
    step(0, 0, 1, 0);
    step(0, 0, 1, 10);
    repeat (HOLD) step(0, 0, 1, 10);
  endtask

  int pulses;

  initial begin
    reset = 1'b1; abort = 1'b0; enable = 1'b0; percent = 4'd0;

    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_state", state, 0);
    chk("rst_pause", pause, 1);

    // Plan 1 and 2: fill, hold exactly 4 cycles, drain down to 0
    step(0, 0, 1, 0);
    chk("p1_fill", state, 1);
    step(0, 0, 1, 10);
    chk("p1_hold", state, 2);
    for (int i = 0; i < HOLD - 1; i++) step(0, 0, 1, 10);
    chk("p1_still_hold", state, 2);
    step(0, 0, 1, 10);
    chk("p1_drain", state, 3);
    for (int p = 8; p >= 2; p -= 2) step(0, 0, 1, p);
    chk("p2_no_early_done", transferDone, 0);
    step(0, 0, 1, 0);
    chk("p2_done", transferDone, 1);
    chk("p2_count", transferCount, 1);
    step(0, 0, 1, 0);
    chk("p2_done_one_cycle", transferDone, 0);

    // Plan 3: drop enable mid-hold
    step(0, 0, 1, 10);
    repeat (HOLD) step(0, 0, 0, 10);
    chk("p3_drain", state, 3);
    step(0, 0, 0, 1);
    chk("p3_idle", state, 0);
    chk("p3_count", transferCount, 2);

    // Plan 4: wrapped level in drain latches error until reset
    run_to_drain();
    step(0, 0, 1, 15);
    chk("p4_err", error, 1);
    repeat (3) step(0, 0, 1, 0);
    chk("p4_stuck_idle", state, 0);
    step(1, 0, 1, 0);
    chk("p4_err_clr", error, 0);

    // Plan 5: abort beats drain completion
    run_to_drain();
    step(0, 1, 1, 1);
    chk("p5_idle", state, 0);
    chk("p5_no_done", transferDone, 0);

    // Reset mid-hold
    step(0, 0, 1, 0);
    step(0, 0, 1, 10);
    step(0, 0, 1, 10);
    step(1, 0, 1, 10);
    chk("rst_mid_hold", state, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit r, a, e;
      int p;
      r = ($urandom_range(0, 99) == 0);
      a = ($urandom_range(0, 49) == 0);
      e = ($urandom_range(0, 9) != 0);
      p = ($urandom_range(0, 99) < 3) ? int'($urandom_range(11, 15)) : int'($urandom_range(0, 10));
      step(r, a, e, p);
    end

    // Plan 6: saturation after 260 back-to-back transfers
    step(1, 0, 0, 0);
    pulses = 0;
    for (int cyc = 0; cyc < 5000 && pulses < 260; cyc++) begin
      step(0, 0, 1, (m_mode == 3) ? 0 : 10);
      if (transferDone) pulses++;
    end
    chk("sat_pulses", pulses, 260);
    chk("sat_count", transferCount, 255);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/buffer_drain_ctrl.md
# buffer_drain_ctrl

Control-side partner of the buffer fill counter. It watches the 4-bit fill level (0–10, in 10 % steps) and generates the `emptyBuffer` and `pause` controls that the fill counter consumes. It runs a fill → hold → drain cycle, counts completed transfers, and detects underflow/out-of-range levels. It sits between the user enable/abort switches and the fill counter.

## Interface

Parameters:
- `FULL_LEVEL`, default 10: level at or above which filling stops.
- `EMPTY_LEVEL`, default 1: level at or below which draining stops. This stops before the counter's −2 step can wrap below 0.
- `HOLD_CYCLES`, default 19'd390625: clocks spent in HOLD before draining. 19-bit; must be ≥ 1.

Ports:
- `clock`  in  1: single clock; all logic on posedge.
- `reset`  in  1: synchronous, active-high.
- `percent`  in  4: current fill level from the fill counter. Legal range 0–10.
- `enable`  in  1: level-sensitive; run transfer cycles while high.
- `abort`  in  1: level-sensitive; forces IDLE.
- `emptyBuffer`  out  1: drain request to the fill counter.
- `pause`  out  1: freeze request to the fill counter.
- `state`  out  2: IDLE=00, FILL=01, HOLD=10, DRAIN=11.
- `full`  out  1: high while in HOLD.
- `transferDone`  out  1: one-cycle pulse when a drain completes.
- `transferCount`  out  8: number of completed drains, saturating at 255.
- `error`  out  1: sticky out-of-range flag.

## Operation

Outputs are Moore, decoded from registered state:
- IDLE: `pause`=1, `emptyBuffer`=0.
- FILL: `pause`=0, `emptyBuffer`=0.
- HOLD: `pause`=1, `emptyBuffer`=0, `full`=1.
- DRAIN: `pause`=0, `emptyBuffer`=1.

Transitions, evaluated each posedge in priority order (reset > abort > error > normal):
- `reset` → IDLE. Hold counter = 0, `transferCount` = 0, `error` = 0, `transferDone` = 0.
- `abort` → IDLE from any state. No `transferDone` pulse, count unchanged, hold counter cleared.
- In FILL or DRAIN, `percent` > 10 → set `error`, go to IDLE. A value of 14 or 15 means the fill counter wrapped.
- IDLE:
  - `enable`=1 and `error`=0 → FILL.
  - With `error`=1, `enable` is ignored.
- FILL:
  - `percent` ≥ `FULL_LEVEL` → HOLD, hold counter = 0.
  - Otherwise, `enable`=0 → IDLE.
- HOLD:
  - Hold counter increments each cycle.
  - When the counter equals `HOLD_CYCLES`−1 → DRAIN.
  - `enable` is ignored; a transfer in progress always completes.
- DRAIN:
  - `percent` ≤ `EMPTY_LEVEL` → pulse `transferDone` and increment `transferCount` (saturating; 255 stays 255).
  - Next state is FILL if `enable`=1, else IDLE.
  - `enable`=0 otherwise has no effect.

Width rules:
- Hold counter is 19 bits.
- Level comparisons are unsigned 4-bit.
- The out-of-range check (> 10) takes precedence over the `EMPTY_LEVEL` and `FULL_LEVEL` compares.

## Timing

- Reset values:
  - `state`=00, `pause`=1, `emptyBuffer`=0.
  - `full`=0, `transferDone`=0, `transferCount`=0, `error`=0.
- Latency from an input condition to the new state and outputs is 1 clock: the condition is sampled at edge N and outputs change after edge N.
- HOLD lasts exactly `HOLD_CYCLES` clocks. If HOLD is entered at edge N, DRAIN is entered at edge N+`HOLD_CYCLES`.
- `transferDone` is high for exactly the cycle after the DRAIN-exit edge. The `transferCount` update is visible in that same cycle.
- FILL→HOLD when `percent` is already ≥ `FULL_LEVEL` on FILL entry takes one cycle; FILL lasts 1 cycle.
- DRAIN entered with `percent` already ≤ `EMPTY_LEVEL`: exits after 1 cycle with `transferDone`.
- `abort` and a DRAIN-exit condition in the same cycle: `abort` wins, no pulse.
- `reset` asserted mid-HOLD or mid-DRAIN: all state clears at that edge, with no pulse.
- No internal wait on the fill counter's 10 % tick. The fill counter changes `percent` at most once per tick, so a one-cycle reaction always lands before its next update.

## Test plan

Bench overrides `HOLD_CYCLES`=4 and drives `percent` directly.

1. Reset, then `enable`=1 with `percent`=0 → `state`=01, `pause`=0. Step `percent` to 10 → next cycle `state`=10, `full`=1, `pause`=1. Exactly 4 cycles later → `state`=11, `emptyBuffer`=1.
2. In DRAIN, step `percent` 10→8→…→2→0 → `transferDone` pulses once (1 cycle) when `percent`=0. `transferCount`=1. `state` returns to 01 since `enable`=1.
3. Drop `enable` mid-HOLD → HOLD and DRAIN complete. After `percent` ≤ 1, `state`=00, `pause`=1, count incremented.
4. In DRAIN, drive `percent`=15 → `error`=1, `state`=00. Later `enable`=1 keeps `state`=00 until `reset`, after which `error`=0.
5. `abort`=1 asserted in the same cycle as `percent`=1 during DRAIN → `state`=00, no `transferDone`, count unchanged.
6. Force 260 back-to-back transfers (`percent` toggling 10/0) → `transferCount` saturates at 255. `transferDone` still pulses on each completion.
